// File: rtl/x25519_byte_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : x25519_byte_frontend
//  Purpose  : Byte-stream front end for the X25519 scalar-multiplication core.
//             Loads a 32-byte little-endian scalar and u-coordinate, applies
//             optional clamping, starts the core once, then streams the
//             256-bit result back out as 32 little-endian bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module x25519_byte_frontend #(
  parameter int CLAMP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         mult_en,
  output logic [255:0] mult_e,
  output logic [255:0] mult_work_in,
  input  logic         mult_out_valid,
  input  logic [255:0] mult_work_out,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_LOAD_E = 3'd0,
    S_LOAD_U = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  // Clamp masks: scalar loses bits 2:0 and 255 and gains bit 254; u loses bit 255.
  localparam logic [255:0] c_E_AND = (CLAMP != 0) ? {2'b00, {251{1'b1}}, 3'b000} : {256{1'b1}};
  localparam logic [255:0] c_E_OR  = (CLAMP != 0) ? {2'b01, 254'd0}              : 256'd0;
  localparam logic [255:0] c_U_AND = (CLAMP != 0) ? {1'b0, {255{1'b1}}}          : {256{1'b1}};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [4:0]     r_cnt;
  logic [4:0]     w_cnt_nxt;
  logic [255:0]   r_e;
  logic [255:0]   r_u;
  logic [255:0]   r_res;
  logic           w_in_hs;
  logic [7:0]     w_bit_ofs;

  assign w_bit_ofs    = {r_cnt, 3'b000};
  assign mult_e       = (r_e & c_E_AND) | c_E_OR;
  assign mult_work_in = r_u & c_U_AND;
  assign out_data     = r_res[w_bit_ofs +: 8];

  // State and byte-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD_E;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs; the 5-bit counter wraps 31->0
  // exactly on the handshakes that leave LOAD_E, LOAD_U and SEND.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    mult_en     = 1'b0;
    busy        = 1'b1;
    w_in_hs     = 1'b0;
    case (r_state)
      S_LOAD_E: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        w_in_hs  = in_valid;
        if (in_valid) begin
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) w_state_nxt = S_LOAD_U;
        end
      end
      S_LOAD_U: begin
        in_ready = 1'b1;
        w_in_hs  = in_valid;
        if (in_valid) begin
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) w_state_nxt = S_START;
        end
      end
      S_START: begin
        mult_en     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mult_out_valid) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == 5'd31);
        if (out_ready) begin
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) w_state_nxt = S_LOAD_E;
        end
      end
      default: begin
        w_state_nxt = S_LOAD_E;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  // Operand bytes are written in place at byte[cnt]; the result is captured
  // only while waiting on the core, so stray core valids are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e   <= 256'd0;
      r_u   <= 256'd0;
      r_res <= 256'd0;
    end else begin
      if (w_in_hs && (r_state == S_LOAD_E)) r_e[w_bit_ofs +: 8] <= in_data;
      if (w_in_hs && (r_state == S_LOAD_U)) r_u[w_bit_ofs +: 8] <= in_data;
      if ((r_state == S_WAIT) && mult_out_valid) r_res <= mult_work_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x25519_byte_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x25519_byte_frontend
//  Purpose  : Self-checking bench for x25519_byte_frontend with a stub core.
//             Result bytes are queued when the stub responds and compared as
//             they leave the front end.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_x25519_byte_frontend;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         out_ready;
  logic         mult_out_valid;
  logic [255:0] mult_work_out;

  logic         in_ready, out_valid, out_last, mult_en, busy;
  logic [7:0]   out_data;
  logic [255:0] mult_e, mult_work_in;

  logic         nc_in_ready, nc_out_valid, nc_out_last, nc_mult_en, nc_busy;
  logic [7:0]   nc_out_data;
  logic [255:0] nc_mult_e, nc_mult_work_in;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  x25519_byte_frontend #(.CLAMP(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mult_en(mult_en), .mult_e(mult_e), .mult_work_in(mult_work_in),
    .mult_out_valid(mult_out_valid), .mult_work_out(mult_work_out), .busy(busy)
  );

  // Unclamped instance sharing the same stimulus, used for the CLAMP=0 pass-through.
  x25519_byte_frontend #(.CLAMP(0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data), .out_last(nc_out_last),
    .mult_en(nc_mult_en), .mult_e(nc_mult_e), .mult_work_in(nc_mult_work_in),
    .mult_out_valid(mult_out_valid), .mult_work_out(mult_work_out), .busy(nc_busy)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] clamp_e(input logic [255:0] x);
    logic [255:0] y;
    y = x;
    y[2:0] = 3'b000;
    y[255] = 1'b0;
    y[254] = 1'b1;
    return y;
  endfunction

  function automatic logic [255:0] clamp_u(input logic [255:0] x);
    logic [255:0] y;
    y = x;
    y[255] = 1'b0;
    return y;
  endfunction

  task automatic pulse_reset();
    logic [255:0] reset_e;
    reset_e = 256'd0;
    reset_e[254] = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mult_out_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst mult_en", mult_en, 0);
    check("rst busy", busy, 0);
    check("rst mult_e", mult_e, reset_e);
    @(posedge clk); #1;
  endtask

  // One byte on the input stream, with optional idle cycles in front of it.
  task automatic push_byte(input logic [7:0] b, input bit gappy);
    if (gappy) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    if (!in_ready) check("in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full transaction against the stub core. abort_load/abort_send >= 0 apply
  // a reset after that many input/output handshakes.
  task automatic run_txn(input logic [255:0] e, input logic [255:0] u, input logic [255:0] res,
                         input bit gappy, input bit rnd_ready, input bit spur,
                         input int abort_load, input int abort_send);
    int got;
    int guard;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    for (int k = 0; k < 64; k++) begin
      if (k == abort_load) begin
        pulse_reset();
        return;
      end
      if (spur && k == 3) begin
        mult_out_valid = 1'b1;
        mult_work_out  = ~res;
      end
      push_byte((k < 32) ? e[8*k +: 8] : u[8*(k-32) +: 8], gappy);
      if (spur && k == 3) begin
        mult_out_valid = 1'b0;
        @(negedge clk);
        check("spur load busy", busy, 0);
        check("spur load in_ready", in_ready, 1);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("mult_en pulse", mult_en, 1);
    check("mult_e clamped", mult_e, clamp_e(e));
    check("mult_work_in clamped", mult_work_in, clamp_u(u));
    check("nc mult_e", nc_mult_e, e);
    check("nc mult_work_in", nc_mult_work_in, u);
    @(posedge clk); #1;
    @(negedge clk);
    check("mult_en one cycle", mult_en, 0);
    check("wait busy", busy, 1);
    check("wait out_valid", out_valid, 0);
    @(posedge clk); #1;
    mult_out_valid = 1'b1;
    mult_work_out  = res;
    for (int k = 0; k < 32; k++) sb_q.push_back(res[8*k +: 8]);
    @(posedge clk); #1;
    mult_out_valid = 1'b0;
    mult_work_out  = ~res;
    got = 0;
    guard = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    while (got < 32 && guard < 2000) begin
      guard++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spur && got == 5) mult_out_valid = 1'b1;
      @(negedge clk);
      check("send out_valid", out_valid, 1);
      if (prev_stall) check("stall hold", out_data, prev_data);
      if (out_ready) begin
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check("out_data", out_data, exp_b);
        check("out_last", out_last, (got == 31));
        got++;
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
      mult_out_valid = 1'b0;
      if (abort_send >= 0 && got == abort_send) begin
        pulse_reset();
        return;
      end
    end
    out_ready = 1'b0;
    if (guard >= 2000) check("send timeout", 0, 1);
    check("scoreboard empty", sb_q.size(), 0);
    @(negedge clk);
    check("next in_ready", in_ready, 1);
    check("next busy", busy, 0);
    check("next out_valid", out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] e_vec, u_vec, r_vec, cnt_vec, r2_vec;
    e_vec = 256'h4efd154fe4e2b3365c3bb5be55aa21ac6cfa4ebc3d7938984eb51bf8f87f1a0b;
    u_vec = 256'ha98249329ef0af94d3047370a21a2b8605cb775f344de032e8ca13a429231ce1;
    r_vec = 256'h16a5809b6050c51eb0b3b00ed972c12e22bc8cb71ac00f99f30c44395bdf3f85;
    for (int k = 0; k < 32; k++) cnt_vec[8*k +: 8] = 8'(k);
    r2_vec = 256'hdeadbeef_0123_4567_89ab_cdef_fedc_ba98_7654_3210_5a5a_a5a5_c3c3_3c3c_0f0f_f0f0;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    mult_out_valid = 1'b0;
    mult_work_out = 256'd0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // Clamp values and little-endian result ordering, plain handshakes.
    check("clamp e literal", clamp_e(e_vec),
          256'h4efd154fe4e2b3365c3bb5be55aa21ac6cfa4ebc3d7938984eb51bf8f87f1a08);
    check("clamp u literal", clamp_u(u_vec),
          256'h298249329ef0af94d3047370a21a2b8605cb775f344de032e8ca13a429231ce1);
    run_txn(e_vec, u_vec, r_vec, 1'b0, 1'b0, 1'b0, -1, -1);

    // Backpressure with input gaps and stray core valids.
    run_txn(u_vec, e_vec, cnt_vec, 1'b1, 1'b1, 1'b1, -1, -1);

    // Reset after 40 input bytes, then a fresh transaction.
    run_txn(e_vec, u_vec, r_vec, 1'b0, 1'b0, 1'b0, 40, -1);
    run_txn(e_vec, u_vec, r2_vec, 1'b0, 1'b0, 1'b0, -1, -1);

    // Reset after 10 output bytes; the rest must never appear.
    run_txn(e_vec, u_vec, r_vec, 1'b0, 1'b1, 1'b0, -1, 10);
    @(negedge clk);
    check("post-reset no resend", out_valid, 0);
    @(posedge clk); #1;
    run_txn(u_vec, e_vec, cnt_vec, 1'b1, 1'b0, 1'b0, -1, -1);

    // Back-to-back transactions with different results.
    run_txn(e_vec, u_vec, r2_vec, 1'b0, 1'b0, 1'b0, -1, -1);
    run_txn(e_vec, u_vec, r_vec, 1'b0, 1'b1, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
